// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signal bundle for mem_arbiter.
// slave = arbiter view, master = requesters plus memory model.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] fill_data;
    logic [2:0]        fill_idx;
    logic              i_fill_valid;
    logic              d_fill_valid;
    logic              i_done;
    logic              d_done;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_rvalid,
        output fill_data, fill_idx, i_fill_valid, d_fill_valid,
        output i_done, d_done,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_rvalid,
        input  fill_data, fill_idx, i_fill_valid, d_fill_valid,
        input  i_done, d_done,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one pipelined memory between
// the I-cache fill path and the D-cache fill/write path.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;
    localparam logic       SIDE_I  = 1'b0;
    localparam logic       SIDE_D  = 1'b1;
    localparam logic       LAT_OK  = (MEM_LAT > 0);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:4] base_q, base_d;
    logic [2:0]        icnt_q, icnt_d;
    logic [2:0]        rcnt_q, rcnt_d;
    logic [DATA_W-1:0] fdata_q;
    logic [2:0]        fidx_q;
    logic              ifv_q, dfv_q;
    logic              idone_q, ddone_q;
    logic              fill_act, ret, hold, pick_dside;
    logic              unused_ok;

    assign fill_act   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign ret        = fill_act && bus.mem_rvalid;
    // A done pulse means the finished requester still shows req;
    // skip sampling for that one cycle so it is not re-granted.
    assign hold       = idone_q | ddone_q;
    assign pick_dside = bus.d_req &&
                        (!bus.i_req || (last_q == SIDE_I));
    assign unused_ok  = ^{bus.i_addr[3:0], LAT_OK};

    // Next-state: grant, issue counting, drain and write sequencing
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        base_d  = base_q;
        icnt_d  = icnt_q;
        rcnt_d  = rcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (!hold && (bus.i_req || bus.d_req)) begin
                    owner_d = pick_dside;
                    last_d  = pick_dside;
                    icnt_d  = 3'd0;
                    rcnt_d  = 3'd0;
                    base_d  = pick_dside ? bus.d_addr[ADDR_W-1:4]
                                         : bus.i_addr[ADDR_W-1:4];
                    state_d = (pick_dside && bus.d_we) ? S_WRITE
                                                       : S_ISSUE;
                end
            end
            S_ISSUE: begin
                icnt_d = icnt_q + 3'd1;
                if (icnt_q == 3'd7) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.mem_rvalid && (rcnt_q == 3'd7)) state_d = S_IDLE;
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (ret) rcnt_d = rcnt_q + 3'd1;
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= SIDE_I;
            last_q  <= SIDE_I;
            base_q  <= '0;
            icnt_q  <= 3'd0;
            rcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            base_q  <= base_d;
            icnt_q  <= icnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // Register each returned word with its index and owner tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fdata_q <= '0;
            fidx_q  <= 3'd0;
            ifv_q   <= 1'b0;
            dfv_q   <= 1'b0;
            idone_q <= 1'b0;
            ddone_q <= 1'b0;
        end else begin
            ifv_q   <= 1'b0;
            dfv_q   <= 1'b0;
            idone_q <= 1'b0;
            ddone_q <= 1'b0;
            if (ret) begin
                fdata_q <= bus.mem_rdata;
                fidx_q  <= rcnt_q;
                ifv_q   <= (owner_q == SIDE_I);
                dfv_q   <= (owner_q == SIDE_D);
                idone_q <= (owner_q == SIDE_I) && (rcnt_q == 3'd7);
                ddone_q <= (owner_q == SIDE_D) && (rcnt_q == 3'd7);
            end
        end
    end

    // Memory strobes; address and data are zero when idle
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (state_q == S_ISSUE) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = {base_q, icnt_q, 1'b0};
        end else if (state_q == S_WRITE) begin
            bus.mem_en    = 1'b1;
            bus.mem_wr    = 1'b1;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end
    end

    assign bus.fill_data    = fdata_q;
    assign bus.fill_idx     = fidx_q;
    assign bus.i_fill_valid = ifv_q;
    assign bus.d_fill_valid = dfv_q;
    assign bus.i_done       = idone_q;
    assign bus.d_done       = ddone_q | (state_q == S_WRITE);
endmodule
